rip_load_store_unit: RTL and testbench

Initiator-side master for the byte-enabled, word-indexed data memory port (we[3:0]/re/addr/din/dout/busy).
- Accepts one load or store per handshake from the pipeline MEM stage.
- Converts the byte address into a word index and byte-lane enables.
- Aligns store data, issues the memory access, waits out busy, and returns sign- or zero-extended load data.
- Sits between the execute/MEM pipeline register and the memory control unit's port 1.

---
 rtl/rip_load_store_unit_pkg.sv | 20 ++
 rtl/rip_lsu_align.sv | 48 ++++
 rtl/rip_load_store_unit.sv | 140 ++++++++++++++
 tb/tb_rip_load_store_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rip_load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM states
// and the funct3 legality check used when a request is accepted.
package rip_common;

  localparam logic [2:0] LS_B  = 3'd0;
  localparam logic [2:0] LS_H  = 3'd1;
  localparam logic [2:0] LS_W  = 3'd2;
  localparam logic [2:0] LS_BU = 3'd4;
  localparam logic [2:0] LS_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, ISSUE, DATA, RESP} lsu_state_t;

  // Stores have no unsigned variants; loads accept all five width codes.
  function automatic logic ls_legal(input logic store, input logic [2:0] f3);
    if (store) return (f3 == LS_B) || (f3 == LS_H) || (f3 == LS_W);
    return (f3 == LS_B) || (f3 == LS_H) || (f3 == LS_W) ||
           (f3 == LS_BU) || (f3 == LS_HU);
  endfunction

endpackage

// File: rtl/rip_lsu_align.sv
// Byte-lane steering: store enables/replicated data, alignment check, and
// load lane extraction with sign or zero extension.
module rip_lsu_align
  import rip_common::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] dout,
  output logic [3:0]  we,
  output logic [31:0] din,
  output logic        misaligned,
  output logic [31:0] rdata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = dout[{addr_lo, 3'b000} +: 8];
  assign lane_h = addr_lo[1] ? dout[31:16] : dout[15:0];

  // funct3[1:0] selects the width; funct3[2] selects zero extension.
  always_comb begin
    we         = 4'b0000;
    din        = wdata;
    misaligned = 1'b0;
    rdata      = dout;
    case (funct3[1:0])
      2'd0: begin
        we    = 4'b0001 << addr_lo;
        din   = {4{wdata[7:0]}};
        rdata = funct3[2] ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      2'd1: begin
        misaligned = addr_lo[0];
        we         = addr_lo[1] ? 4'b1100 : 4'b0011;
        din        = {2{wdata[15:0]}};
        rdata      = funct3[2] ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      end
      2'd2: begin
        misaligned = (addr_lo != 2'b00);
        we         = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rip_load_store_unit.sv
// Load/store master for the byte-enabled word memory port: one request in
// flight, waits out busy, returns extended load data.
//
// state | meaning
// IDLE  | ready for a request; errors go straight to RESP
// ISSUE | memory access driven, held while mem_busy
// DATA  | load data on mem_dout, extract and register
// RESP  | one-cycle resp_valid
module rip_load_store_unit
  import rip_common::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic [3:0]            mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  mem_busy
);

  lsu_state_t            state_q, state_d;
  logic                  store_q, store_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  error_q, error_d;

  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_we;
  logic [31:0] al_din;
  logic        al_misaligned;
  logic [31:0] al_rdata;

  // In IDLE the aligner checks the incoming request; afterwards it works on the latched one.
  assign al_funct3  = (state_q == IDLE) ? req_funct3    : funct3_q;
  assign al_addr_lo = (state_q == IDLE) ? req_addr[1:0] : addr_q[1:0];

  rip_lsu_align u_align (
    .funct3     (al_funct3),
    .addr_lo    (al_addr_lo),
    .wdata      (wdata_q),
    .dout       (mem_dout),
    .we         (al_we),
    .din        (al_din),
    .misaligned (al_misaligned),
    .rdata      (al_rdata)
  );

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    error_d  = error_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (!ls_legal(req_store, req_funct3) || al_misaligned) begin
            state_d = RESP;
            rdata_d = '0;
            error_d = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!mem_busy) begin
          if (store_q) begin
            state_d = RESP;
            rdata_d = '0;
            error_d = 1'b0;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        rdata_d = al_rdata;
        error_d = 1'b0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

  // Port signals decode from state so a reset drops them without waiting for an edge.
  assign mem_re   = (state_q == ISSUE) && !store_q;
  assign mem_we   = ((state_q == ISSUE) && store_q) ? al_we : 4'b0000;
  assign mem_din  = ((state_q == ISSUE) && store_q) ? al_din : '0;
  assign mem_addr = (state_q == ISSUE) ? {2'b00, addr_q[ADDR_WIDTH-1:2]} : '0;

endmodule

// File: tb/tb_rip_load_store_unit.sv
// Directed bench for rip_load_store_unit with a small byte-enabled memory model.
module tb_rip_load_store_unit;
  import rip_common::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [3:0]  mem_we;
  logic        mem_re;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_busy;

  rip_load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (!mem_busy) begin
      if (mem_re) mem_dout <= mem[mem_addr[5:0]];
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) mem[mem_addr[5:0]][8*i +: 8] <= mem_din[8*i +: 8];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          lat, re_cyc, we_cyc, busy_n;
  logic [31:0] r_data, s_din, s_addr;
  logic [3:0]  s_we;
  logic        r_err, rdy_bad;

  task automatic lsu(input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd);
    bit done;
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; re_cyc = 0; we_cyc = 0; s_we = '0; s_din = '0; s_addr = '0;
    rdy_bad = 1'b0; done = 1'b0; r_data = 'x; r_err = 1'bx;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
      if (req_ready) rdy_bad = 1'b1;
      if (mem_re) begin re_cyc++; s_addr = mem_addr; end
      if (mem_we != 4'b0000) begin
        we_cyc++; s_we = mem_we; s_din = mem_din; s_addr = mem_addr;
      end
      if (resp_valid) begin
        done = 1'b1; r_data = resp_rdata; r_err = resp_error;
      end
      mem_busy = (lat <= busy_n);
    end
    mem_busy = 1'b0;
    if (!done) check("timeout", 32'd0, 32'd1);
    else begin
      @(negedge clk);
      check("pulse_one_cycle", {31'd0, resp_valid}, 32'd0);
    end
  endtask

  bit seen_resp;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; mem_busy = 1'b0; busy_n = 0;
    #12;
    check("rst_ready",  {31'd0, req_ready},  32'd1);
    check("rst_valid",  {31'd0, resp_valid}, 32'd0);
    check("rst_rdata",  resp_rdata,          32'd0);
    check("rst_error",  {31'd0, resp_error}, 32'd0);
    check("rst_we",     {28'd0, mem_we},     32'd0);
    check("rst_re",     {31'd0, mem_re},     32'd0);
    check("rst_addr",   mem_addr,            32'd0);
    check("rst_din",    mem_din,             32'd0);
    @(negedge clk); rst = 1'b0;

    // store word then load word
    lsu(1'b1, LS_W, 32'h10, 32'hDEADBEEF);
    check("sw_lat",  lat,            32'd2);
    check("sw_we",   {28'd0, s_we},  32'hF);
    check("sw_addr", s_addr,         32'd4);
    check("sw_din",  s_din,          32'hDEADBEEF);
    check("sw_rdata", r_data,        32'd0);
    check("sw_err",  {31'd0, r_err}, 32'd0);
    check("sw_ready_low", {31'd0, rdy_bad}, 32'd0);
    lsu(1'b0, LS_W, 32'h10, 32'h0);
    check("lw_lat",   lat,    32'd3);
    check("lw_rdata", r_data, 32'hDEADBEEF);
    check("lw_re",    re_cyc, 32'd1);

    // byte store into a known word
    lsu(1'b1, LS_W, 32'h10, 32'h11223344);
    lsu(1'b1, LS_B, 32'h13, 32'h000000A5);
    check("sb_we",  {28'd0, s_we}, 32'h8);
    check("sb_din", s_din,         32'hA5A5A5A5);
    check("sb_lat", lat,           32'd2);
    lsu(1'b0, LS_W, 32'h10, 32'h0);
    check("sb_word", r_data, 32'hA5223344);
    lsu(1'b1, LS_H, 32'h12, 32'h0000BEEF);
    check("sh_we",  {28'd0, s_we}, 32'hC);
    check("sh_din", s_din,         32'hBEEFBEEF);
    lsu(1'b0, LS_W, 32'h10, 32'h0);
    check("sh_word", r_data, 32'hBEEF3344);

    // load extension
    lsu(1'b1, LS_W, 32'h20, 32'h80FF7F01);
    lsu(1'b0, LS_B,  32'h22, 32'h0); check("lb_22",  r_data, 32'hFFFFFFFF);
    lsu(1'b0, LS_BU, 32'h22, 32'h0); check("lbu_22", r_data, 32'h000000FF);
    lsu(1'b0, LS_B,  32'h20, 32'h0); check("lb_20",  r_data, 32'h00000001);
    lsu(1'b0, LS_B,  32'h21, 32'h0); check("lb_21",  r_data, 32'h0000007F);
    lsu(1'b0, LS_H,  32'h22, 32'h0); check("lh_22",  r_data, 32'hFFFF80FF);
    lsu(1'b0, LS_HU, 32'h22, 32'h0); check("lhu_22", r_data, 32'h000080FF);
    lsu(1'b0, LS_H,  32'h20, 32'h0); check("lh_20",  r_data, 32'h00007F01);

    // misaligned / illegal
    lsu(1'b0, LS_W, 32'h21, 32'h0);
    check("lw_mis_lat", lat, 32'd1);
    check("lw_mis_err", {31'd0, r_err}, 32'd1);
    check("lw_mis_rdata", r_data, 32'd0);
    check("lw_mis_mem", re_cyc + we_cyc, 32'd0);
    lsu(1'b1, 3'd3, 32'h10, 32'h12345678);
    check("st_ill_lat", lat, 32'd1);
    check("st_ill_err", {31'd0, r_err}, 32'd1);
    check("st_ill_rdata", r_data, 32'd0);
    check("st_ill_mem", re_cyc + we_cyc, 32'd0);
    lsu(1'b1, LS_H, 32'h11, 32'h0);
    check("sh_mis_err", {31'd0, r_err}, 32'd1);
    check("sh_mis_mem", re_cyc + we_cyc, 32'd0);
    lsu(1'b0, 3'd6, 32'h20, 32'h0);
    check("ld_ill_err", {31'd0, r_err}, 32'd1);
    lsu(1'b0, LS_W, 32'h10, 32'h0);
    check("after_err_word", r_data, 32'hBEEF3344);
    check("after_err_err", {31'd0, r_err}, 32'd0);

    // busy stall
    busy_n = 3;
    lsu(1'b0, LS_W, 32'h20, 32'h0);
    busy_n = 0;
    check("busy_lat",   lat,    32'd6);
    check("busy_re",    re_cyc, 32'd4);
    check("busy_rdata", r_data, 32'h80FF7F01);
    check("busy_ready_low", {31'd0, rdy_bad}, 32'd0);

    // reset mid-access
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = LS_W;
    req_addr = 32'h30; req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0; mem_busy = 1'b1;
    @(negedge clk);
    check("mid_we_before", {28'd0, mem_we}, 32'hF);
    rst = 1'b1;
    #1;
    check("mid_we_after", {28'd0, mem_we}, 32'd0);
    check("mid_ready",    {31'd0, req_ready}, 32'd1);
    check("mid_valid",    {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_busy = 1'b0;
    seen_resp = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid) seen_resp = 1'b1;
    end
    check("mid_no_resp", {31'd0, seen_resp}, 32'd0);
    lsu(1'b0, LS_W, 32'h20, 32'h0);
    check("post_rst_lat",   lat,    32'd3);
    check("post_rst_rdata", r_data, 32'h80FF7F01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
